// File: rtl/wrn_mqueue_slot_array.sv
// Multi-slot message queue: every slot is a circular buffer of variable-length messages
// kept in one shared RAM. The producer claims, writes and commits; the consumer reads and discards.
module wrn_mqueue_slot_array #(
  parameter int g_num_slots    = 4,
  parameter int g_entries_log2 = 2,
  parameter int g_words_log2   = 3,
  parameter int g_data_width   = 32,
  localparam int SW = (g_num_slots > 1) ? $clog2(g_num_slots) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [SW-1:0]           in_slot_i,
  input  logic                    in_claim_i,
  output logic                    in_claimed_o,
  output logic                    in_claim_err_o,
  input  logic                    in_we_i,
  input  logic [g_words_log2-1:0] in_addr_i,
  input  logic [g_data_width-1:0] in_data_i,
  input  logic                    in_commit_i,
  input  logic [SW-1:0]           out_slot_i,
  input  logic [g_words_log2-1:0] out_addr_i,
  output logic [g_data_width-1:0] out_data_o,
  output logic [g_words_log2:0]   out_len_o,
  input  logic                    out_discard_i,
  output logic [g_num_slots-1:0]  slot_full_o,
  output logic [g_num_slots-1:0]  slot_empty_o,
  input  logic [g_num_slots-1:0]  irq_mask_i,
  output logic                    irq_o
);

  localparam int EL      = g_entries_log2;
  localparam int WL      = g_words_log2;
  localparam int DW      = g_data_width;
  localparam int LW      = WL + 1;
  localparam int CW      = EL + 1;
  localparam int NSP     = 2 ** SW;
  localparam int ENTRIES = 2 ** EL;
  localparam int AW      = SW + EL + WL;

  localparam logic [SW:0]   NS_L     = (SW + 1)'(g_num_slots);
  localparam logic [CW-1:0] FULL_CNT = CW'(ENTRIES);

  typedef enum logic {ST_IDLE, ST_CLAIMED} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [LW-1:0] run_len_q, run_len_d;
  logic          claim_err_q, claim_err_d;
  logic          commit;
  logic [LW-1:0] commit_len;
  logic [LW-1:0] wr_len;
  logic          discard_ok;

  logic [EL-1:0] wr_ptr_q [NSP];
  logic [EL-1:0] rd_ptr_q [NSP];
  logic [CW-1:0] count_q  [NSP];
  logic [LW-1:0] len_q    [NSP][ENTRIES];
  logic [DW-1:0] mem      [2**AW];

  logic [DW-1:0]  out_data_q;
  logic           irq_q;
  logic [NSP-1:0] full_v, empty_v, inc_v, dec_v;

  always_comb begin
    for (int s = 0; s < NSP; s++) begin
      full_v[s]  = (count_q[s] == FULL_CNT);
      empty_v[s] = (count_q[s] == '0);
    end
  end

  assign slot_full_o    = full_v[g_num_slots-1:0];
  assign slot_empty_o   = empty_v[g_num_slots-1:0];
  assign in_claimed_o   = (state_q == ST_CLAIMED);
  assign in_claim_err_o = claim_err_q;
  assign out_data_o     = out_data_q;
  assign irq_o          = irq_q;

  // A write in the commit cycle still extends the committed length.
  assign wr_len = LW'(in_addr_i) + LW'(1);

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    run_len_d   = run_len_q;
    claim_err_d = 1'b0;
    commit      = 1'b0;
    commit_len  = run_len_q;
    if (in_we_i && (wr_len > run_len_q)) commit_len = wr_len;
    case (state_q)
      ST_IDLE: begin
        if (in_claim_i) begin
          if (({1'b0, in_slot_i} < NS_L) && !full_v[in_slot_i]) begin
            state_d   = ST_CLAIMED;
            slot_d    = in_slot_i;
            run_len_d = '0;
          end else begin
            claim_err_d = 1'b1;
          end
        end
      end
      ST_CLAIMED: begin
        run_len_d = commit_len;
        if (in_commit_i) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign discard_ok = out_discard_i && !empty_v[out_slot_i];

  always_comb begin
    for (int s = 0; s < NSP; s++) begin
      inc_v[s] = commit && (slot_q == SW'(s));
      dec_v[s] = discard_ok && (out_slot_i == SW'(s));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      run_len_q   <= '0;
      claim_err_q <= 1'b0;
      irq_q       <= 1'b0;
      out_data_q  <= '0;
      for (int s = 0; s < NSP; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      run_len_q   <= run_len_d;
      claim_err_q <= claim_err_d;
      irq_q       <= |(~empty_v[g_num_slots-1:0] & irq_mask_i);
      out_data_q  <= mem[{out_slot_i, rd_ptr_q[out_slot_i], out_addr_i}];
      for (int s = 0; s < NSP; s++) begin
        if (inc_v[s]) wr_ptr_q[s] <= wr_ptr_q[s] + EL'(1);
        if (dec_v[s]) rd_ptr_q[s] <= rd_ptr_q[s] + EL'(1);
        count_q[s] <= count_q[s] + CW'(inc_v[s]) - CW'(dec_v[s]);
      end
    end
  end

  // Message storage and lengths carry no reset; visibility is governed by count alone.
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_CLAIMED) && in_we_i)
      mem[{slot_q, wr_ptr_q[slot_q], in_addr_i}] <= in_data_i;
    if (commit)
      len_q[slot_q][wr_ptr_q[slot_q]] <= commit_len;
  end

  always_comb begin
    out_len_o = '0;
    if (!empty_v[out_slot_i]) out_len_o = len_q[out_slot_i][rd_ptr_q[out_slot_i]];
  end

endmodule

// File: tb/tb_wrn_mqueue_slot_array.sv
// Bench for wrn_mqueue_slot_array: directed scenarios plus random traffic against a
// queue-of-messages reference model, with read data checked by a separate monitor.
module tb_wrn_mqueue_slot_array;
  localparam int NS = 4;
  localparam int ENT = 4;
  localparam int WORDS = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    in_slot;
  logic          in_claim;
  logic          in_claimed;
  logic          in_claim_err;
  logic          in_we;
  logic [2:0]    in_addr;
  logic [DW-1:0] in_data;
  logic          in_commit;
  logic [1:0]    out_slot;
  logic [2:0]    out_addr;
  logic [DW-1:0] out_data;
  logic [3:0]    out_len;
  logic          out_discard;
  logic [NS-1:0] slot_full;
  logic [NS-1:0] slot_empty;
  logic [NS-1:0] irq_mask;
  logic          irq;

  wrn_mqueue_slot_array #(
    .g_num_slots(4), .g_entries_log2(2), .g_words_log2(3), .g_data_width(32)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_slot_i(in_slot), .in_claim_i(in_claim), .in_claimed_o(in_claimed),
    .in_claim_err_o(in_claim_err), .in_we_i(in_we), .in_addr_i(in_addr),
    .in_data_i(in_data), .in_commit_i(in_commit),
    .out_slot_i(out_slot), .out_addr_i(out_addr), .out_data_o(out_data),
    .out_len_o(out_len), .out_discard_i(out_discard),
    .slot_full_o(slot_full), .slot_empty_o(slot_empty),
    .irq_mask_i(irq_mask), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]              len;
    logic [WORDS-1:0]        wm;
    logic [WORDS-1:0][DW-1:0] w;
  } msg_t;

  msg_t          mq [NS][$];
  msg_t          cur;
  int            cur_slot;
  bit            claimed;
  logic [DW-1:0] exp_q [$];
  bit            rd_req;
  int            checks;
  int            failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] m_empty();
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = (mq[s].size() == 0);
    return v;
  endfunction

  function automatic logic [NS-1:0] m_full();
    logic [NS-1:0] v;
    for (int s = 0; s < NS; s++) v[s] = (mq[s].size() == ENT);
    return v;
  endfunction

  task automatic step();
    logic exp_irq;
    exp_irq = |(~m_empty() & irq_mask);
    @(posedge clk);
    #1;
    chk("irq", irq, exp_irq);
  endtask

  task automatic chk_flags();
    chk("slot_empty", slot_empty, m_empty());
    chk("slot_full", slot_full, m_full());
  endtask

  task automatic model_write(input int a, input logic [DW-1:0] d);
    cur.w[a]  = d;
    cur.wm[a] = 1'b1;
    if (a + 1 > int'(cur.len)) cur.len = 5'(a + 1);
  endtask

  task automatic claim(input int s);
    bit full;
    full = (mq[s].size() == ENT);
    in_slot = 2'(s);
    in_claim = 1'b1;
    step();
    in_claim = 1'b0;
    chk("claimed", in_claimed, !full);
    chk("claim_err", in_claim_err, full);
    if (!full) begin
      claimed = 1'b1;
      cur_slot = s;
      cur.len = '0;
      cur.wm = '0;
    end else begin
      step();
      chk("claim_err_pulse", in_claim_err, 1'b0);
      chk("claimed_after_err", in_claimed, 1'b0);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    in_we = 1'b1;
    in_addr = 3'(a);
    in_data = d;
    step();
    in_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic commit(input bit we, input int a, input logic [DW-1:0] d, input bit disc);
    in_commit = 1'b1;
    in_we = we;
    in_addr = 3'(a);
    in_data = d;
    if (disc) begin
      out_slot = 2'(cur_slot);
      out_discard = 1'b1;
    end
    step();
    in_commit = 1'b0;
    in_we = 1'b0;
    out_discard = 1'b0;
    if (we) model_write(a, d);
    if (disc && mq[cur_slot].size() > 0) void'(mq[cur_slot].pop_front());
    mq[cur_slot].push_back(cur);
    claimed = 1'b0;
    chk("claimed_after_commit", in_claimed, 1'b0);
    chk_flags();
  endtask

  task automatic discard(input int s);
    out_slot = 2'(s);
    out_discard = 1'b1;
    step();
    out_discard = 1'b0;
    if (mq[s].size() > 0) void'(mq[s].pop_front());
    chk_flags();
  endtask

  task automatic read_msg(input int s);
    msg_t m;
    int l;
    out_slot = 2'(s);
    #1;
    l = (mq[s].size() > 0) ? int'(mq[s][0].len) : 0;
    chk("out_len", out_len, l);
    if (mq[s].size() > 0) begin
      m = mq[s][0];
      for (int a = 0; a < int'(m.len); a++) begin
        out_addr = 3'(a);
        rd_req = m.wm[a];
        if (m.wm[a]) exp_q.push_back(m.w[a]);
        step();
      end
      rd_req = 1'b0;
    end
  endtask

  task automatic send(input int s, input int len, input logic [DW-1:0] base);
    claim(s);
    for (int a = 0; a < len; a++) wr(a, base + DW'(a));
    commit(1'b0, 0, '0, 1'b0);
  endtask

  task automatic drain(input int s);
    while (mq[s].size() > 0) begin
      read_msg(s);
      discard(s);
    end
  endtask

  // Read-data monitor: a read issued before an edge is compared on the following falling edge.
  initial begin
    bit fire;
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      fire = rd_req;
      @(negedge clk);
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data_unexpected actual=%0h expected=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_slot = '0; in_claim = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0;
    in_commit = 1'b0; out_slot = '0; out_addr = '0; out_discard = 1'b0; irq_mask = '0;
    rd_req = 1'b0; claimed = 1'b0; checks = 0; failures = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", slot_empty, 4'hF);
    chk("rst_full", slot_full, 4'h0);
    chk("rst_claimed", in_claimed, 1'b0);
    chk("rst_claim_err", in_claim_err, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_len", out_len, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 5-word message through slot 0
    claim(0);
    for (int a = 0; a < 5; a++) wr(a, DW'(a + 1));
    commit(1'b0, 0, '0, 1'b0);
    chk("t1_not_empty", slot_empty[0], 1'b0);
    read_msg(0);
    chk("t1_len", out_len, 4'd5);
    discard(0);
    chk("t1_empty", slot_empty[0], 1'b1);

    // Fill slot 1, then a refused claim
    for (int i = 0; i < ENT; i++) send(1, i + 1, 32'h1000 * (i + 1));
    chk("t2_full", slot_full[1], 1'b1);
    claim(1);
    drain(1);

    // Pointer wrap on slot 2
    send(2, 3, 32'h2000); send(2, 2, 32'h2100); send(2, 1, 32'h2200); send(2, 4, 32'h2300);
    for (int i = 0; i < 6; i++) begin
      read_msg(2);
      discard(2);
      send(2, $urandom_range(0, WORDS), $urandom);
    end
    drain(2);

    // Same-cycle commit and discard on slot 3
    send(3, 2, 32'h3000); send(3, 3, 32'h3100);
    claim(3);
    wr(0, 32'h3200);
    commit(1'b1, 1, 32'h3201, 1'b1);
    chk("t4_len_head", out_len, 4'd3);
    read_msg(3);
    drain(3);

    // Masked interrupt
    irq_mask = 4'b0010;
    send(0, 1, 32'h4000);
    step();
    chk("t5_irq_masked", irq, 1'b0);
    send(1, 2, 32'h4100);
    step();
    chk("t5_irq_set", irq, 1'b1);
    discard(1);
    step();
    chk("t5_irq_clear", irq, 1'b0);
    drain(0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 5);
      if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom);
      case (op)
        0: begin
          if (!claimed) claim($urandom_range(0, NS - 1));
          else begin
            in_slot = 2'($urandom);
            in_claim = 1'b1;
            step();
            in_claim = 1'b0;
            chk("reclaim_ignored", in_claimed, 1'b1);
            chk("reclaim_no_err", in_claim_err, 1'b0);
          end
        end
        1, 2: if (claimed) wr($urandom_range(0, WORDS - 1), $urandom);
        3: if (claimed) commit(1'($urandom), $urandom_range(0, WORDS - 1), $urandom,
                               ($urandom_range(0, 3) == 0));
        4: read_msg($urandom_range(0, NS - 1));
        default: discard($urandom_range(0, NS - 1));
      endcase
    end
    if (claimed) commit(1'b0, 0, '0, 1'b0);
    for (int s = 0; s < NS; s++) drain(s);

    // Reset in the middle of a claim
    irq_mask = 4'hF;
    send(2, 2, 32'h5000);
    claim(0);
    wr(0, 32'h6000); wr(1, 32'h6001); wr(2, 32'h6002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_claimed", in_claimed, 1'b0);
    chk("rstmid_empty", slot_empty, 4'hF);
    chk("rstmid_irq", irq, 1'b0);
    chk("rstmid_out_len", out_len, '0);
    for (int s = 0; s < NS; s++) mq[s].delete();
    claimed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 3, 32'h7000);
    read_msg(0);
    discard(0);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrn_mqueue_slot_array.md
Name: wrn_mqueue_slot_array

Overview:
- Parametrised multi-slot message queue; the next generation of the single-queue CPU/host mqueue.
- Each of g_num_slots independent slots is a circular buffer of g_entries messages, each up to 2**g_words_log2 words, all in one shared RAM.
- Producer side (CPU shared-interconnect bridge) uses a claim/write/commit protocol; consumer side (host bridge) reads by slot/word and discards.
- Adds per-message length, per-slot full/empty flags, claim error and a maskable, registered interrupt.

Parameters:
- g_num_slots, 4, number of independent slots (1..16).
- g_entries_log2, 2, log2 of messages per slot.
- g_words_log2, 3, log2 of max words per message.
- g_data_width, 32, word width in bits.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- in_slot_i  in  clog2(g_num_slots)  producer slot select, sampled on in_claim_i.
- in_claim_i  in  1  claim request pulse.
- in_claimed_o  out  1  high while a slot is claimed.
- in_claim_err_o  out  1  one-cycle pulse: claim refused.
- in_we_i  in  1  word write strobe.
- in_addr_i  in  g_words_log2  word index in message.
- in_data_i  in  g_data_width  write data.
- in_commit_i  in  1  commit claimed message.
- out_slot_i  in  clog2(g_num_slots)  consumer slot select.
- out_addr_i  in  g_words_log2  word index in head message.
- out_data_o  out  g_data_width  read data, 1-cycle latency.
- out_len_o  out  g_words_log2+1  length of head message of out_slot_i (combinational); 0 if empty.
- out_discard_i  in  1  pop head message of out_slot_i.
- slot_full_o  out  g_num_slots  per-slot full flags.
- slot_empty_o  out  g_num_slots  per-slot empty flags.
- irq_mask_i  in  g_num_slots  interrupt enable per slot.
- irq_o  out  1  interrupt.

Behaviour:
- Reset (async): all counts and pointers 0; producer FSM IDLE; slot_empty_o all 1; slot_full_o, in_claimed_o, in_claim_err_o, irq_o, out_data_o all 0. RAM contents are not cleared.
- Per slot: wr_ptr and rd_ptr (g_entries_log2 bits, natural wrap), count (g_entries_log2+1 bits), and len[entry].
  - full = (count == 2**g_entries_log2); empty = (count == 0); both flags combinational from count.
- Producer FSM, IDLE:
  - in_claim_i on a non-full slot -> CLAIMED next cycle; latch slot; clear running length.
  - in_claim_i on a full slot -> in_claim_err_o pulses next cycle; FSM stays IDLE.
  - in_we_i and in_commit_i ignored.
- Producer FSM, CLAIMED:
  - in_we_i writes RAM[slot][wr_ptr][in_addr_i].
  - Running length = max(running, in_addr_i+1).
  - in_commit_i: len[wr_ptr] <= running length (a same-cycle write counts); wr_ptr++; count++; -> IDLE.
  - Commit with no writes gives length 0 and is still queued.
  - A new in_claim_i while CLAIMED is ignored.
- Consumer reads:
  - out_data_o registered from RAM[out_slot_i][rd_ptr][out_addr_i]; valid one cycle after address presented.
  - If the slot is empty, out_data_o content is don't-care.
- Discard: out_discard_i on a non-empty slot -> rd_ptr++, count--. Discard on an empty slot is ignored.
- Commit and discard on the same slot in the same cycle: both pointers advance; count unchanged; full/empty unchanged.
- Slot full at claim time cannot occur after claim: the claim reserves nothing, but the consumer can only reduce count, so a commit never overflows.
- irq_o is registered: irq_o <= |(~slot_empty_o & irq_mask_i). It asserts one cycle after a commit or mask change, and deasserts one cycle after the last masked slot empties.
- Reset mid-claim: claim is abandoned; no partial message is visible afterwards.

Test Plan:
- Claim slot 0, write words 0..4 = 1,2,3,4,5, commit -> slot_empty_o[0]=0; out_len_o=5 on slot 0; reading addr 0..4 returns 1..5 one cycle after each address; discard -> slot_empty_o[0]=1.
- Commit 4 messages to slot 1 (g_entries_log2=2) -> slot_full_o[1]=1; fifth claim -> in_claim_err_o one pulse; in_claimed_o stays 0.
- Fill slot 2 with messages of lengths 3,2,1,4, then discard/commit 6 more with distinct data -> pointer wrap; returned lengths and data in FIFO order.
- With slot 3 holding 2 messages, commit to slot 3 and discard slot 3 in the same cycle -> count stays 2; head data is the former second message.
- irq_mask_i=4'b0010; commit to slot 0 -> irq_o stays 0; commit to slot 1 -> irq_o=1 after one cycle; discard slot 1 -> irq_o=0 after one cycle.
- Assert rst_n_i while CLAIMED after 3 writes -> in_claimed_o=0 immediately; all slot_empty_o=1; a subsequent claim succeeds.
